// File: rtl/vga_timing_decoder_if.sv
// Sync-level video input bundle: h_sync, v_sync, blank_n.
// master: sync generator side; slave: timing decoder side.
interface vga_timing_decoder_if;
  logic h_sync;
  logic v_sync;
  logic blank_n;

  modport master (
    output h_sync,
    output v_sync,
    output blank_n
  );

  modport slave (
    input h_sync,
    input v_sync,
    input blank_n
  );
endinterface

// File: rtl/vga_timing_decoder.sv
// VGA timing decoder: recovers pixel position, line period and frame
// height from h_sync/v_sync/blank_n, tracks lock and flags violations.
// Ports: clk, rst (sync, active-high), vin (slave: h_sync, v_sync,
//   blank_n), locked, line_start, frame_start, pix_valid, posx, posy,
//   h_period, v_lines, err, err_sticky, err_count.
// Macro VGA_DEC_ERRCNT_EN: enables the saturating err_count counter;
//   when undefined err_count is tied to 0.
module vga_timing_decoder #(
  parameter int CW              = 12,
  parameter int LINE_TOL        = 0,
  parameter int MIN_LINES       = 100,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_timing_decoder_if.slave  vin,
  output logic                 locked,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 pix_valid,
  output logic [9:0]           posx,
  output logic [9:0]           posy,
  output logic [CW-1:0]        h_period,
  output logic [10:0]          v_lines,
  output logic                 err,
  output logic                 err_sticky,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } st_e;

  st_e          st_q, st_d;
  logic         hs_q, vs_q, bl_q;
  logic         hs_p_q, vs_p_q;
  logic [CW-1:0] hcnt_q;
  logic [10:0]  lcnt_q;
  logic [CW-1:0] hper_q;
  logic [10:0]  vlin_q;
  logic         have_q, have_d;
  logic         locked_q, lock_d;
  logic         err_q, err_d;
  logic         sticky_q;
  logic         ls_q, fs_q, pv_q;
  logic [9:0]   posx_q, posy_q;
  logic         row_pix_q;
  logic         per_we, vl_we;

  logic         hs_a, hs_pa, vs_a, vs_pa;
  logic         hs_edge, vs_edge;
  logic [CW:0]  len, per_x, diff;
  logic         line_bad;
  logic [10:0]  fcnt;
  logic         frame_ok, frame_bad;
  logic         tmo;

  // Map raw sync levels onto "active" so edge logic is polarity-free.
  always_comb begin
    hs_a  = (SYNC_ACTIVE_LOW != 0) ? ~hs_q   : hs_q;
    hs_pa = (SYNC_ACTIVE_LOW != 0) ? ~hs_p_q : hs_p_q;
    vs_a  = (SYNC_ACTIVE_LOW != 0) ? ~vs_q   : vs_q;
    vs_pa = (SYNC_ACTIVE_LOW != 0) ? ~vs_p_q : vs_p_q;
  end

  assign hs_edge = hs_a & ~hs_pa;
  assign vs_edge = vs_a & ~vs_pa;

  assign len   = {1'b0, hcnt_q} + {{CW{1'b0}}, 1'b1};
  assign per_x = {1'b0, hper_q};
  assign diff  = (len >= per_x) ? (len - per_x) : (per_x - len);
  assign line_bad = diff > (CW+1)'(LINE_TOL);

  // Frame line count includes a line ending on the vsync edge itself.
  assign fcnt = (hs_edge && !(&lcnt_q)) ? lcnt_q + 11'd1 : lcnt_q;
  assign frame_ok  = fcnt >= 11'(MIN_LINES);
  assign frame_bad = fcnt != vlin_q;

  assign tmo = &hcnt_q;

  always_comb begin
    st_d   = st_q;
    lock_d = locked_q;
    have_d = have_q;
    err_d  = 1'b0;
    per_we = 1'b0;
    vl_we  = 1'b0;
    unique case (st_q)
      SEARCH: begin
        if (vs_edge) begin
          st_d   = MEASURE;
          have_d = 1'b0;
        end
      end
      MEASURE: begin
        if (tmo) begin
          st_d = SEARCH;
        end else if (hs_edge && have_q && line_bad) begin
          st_d = SEARCH;
        end else begin
          if (hs_edge && !have_q) begin
            per_we = 1'b1;
            have_d = 1'b1;
          end
          if (vs_edge) begin
            if (frame_ok) begin
              st_d   = LOCKED;
              lock_d = 1'b1;
              vl_we  = 1'b1;
            end else begin
              st_d = SEARCH;
            end
          end
        end
      end
      LOCKED: begin
        if (tmo || (hs_edge && line_bad) ||
            (vs_edge && frame_bad)) begin
          st_d   = SEARCH;
          lock_d = 1'b0;
          err_d  = 1'b1;
        end
      end
      default: begin
        st_d   = SEARCH;
        lock_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= SEARCH;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      bl_q      <= 1'b0;
      hs_p_q    <= 1'b0;
      vs_p_q    <= 1'b0;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      hper_q    <= '0;
      vlin_q    <= '0;
      have_q    <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      pv_q      <= 1'b0;
      posx_q    <= '0;
      posy_q    <= '0;
      row_pix_q <= 1'b0;
    end else begin
      hs_q     <= vin.h_sync;
      vs_q     <= vin.v_sync;
      bl_q     <= vin.blank_n;
      hs_p_q   <= hs_q;
      vs_p_q   <= vs_q;
      st_q     <= st_d;
      locked_q <= lock_d;
      have_q   <= have_d;
      err_q    <= err_d;
      if (err_d) sticky_q <= 1'b1;
      if (per_we) hper_q <= len[CW-1:0];
      if (vl_we) vlin_q <= fcnt;
      if (hs_edge || (st_q == SEARCH && vs_edge))
        hcnt_q <= '0;
      else if (!tmo)
        hcnt_q <= hcnt_q + 1'b1;
      if (vs_edge)
        lcnt_q <= '0;
      else if (hs_edge && !(&lcnt_q))
        lcnt_q <= lcnt_q + 11'd1;
      ls_q <= hs_edge & lock_d;
      fs_q <= vs_edge & lock_d;
      pv_q <= bl_q & lock_d;
      if (hs_edge)
        posx_q <= '0;
      else if (pv_q && !(&posx_q))
        posx_q <= posx_q + 10'd1;
      if (hs_edge)
        row_pix_q <= 1'b0;
      else if (pv_q)
        row_pix_q <= 1'b1;
      if (vs_edge)
        posy_q <= '0;
      else if (hs_edge && (row_pix_q || pv_q) && !(&posy_q))
        posy_q <= posy_q + 10'd1;
    end
  end

`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] ecnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      ecnt_q <= '0;
    else if (err_d && !(&ecnt_q))
      ecnt_q <= ecnt_q + 8'd1;
  end

  assign err_count = ecnt_q;
`else
  assign err_count = '0;
`endif

  assign locked      = locked_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign pix_valid   = pv_q;
  assign posx        = posx_q;
  assign posy        = posy_q;
  assign h_period    = hper_q;
  assign v_lines     = vlin_q;
  assign err         = err_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a scaled-down raster
// (40 clk/line, 12 lines; tiny 8x4 frames for counter tests).
module tb_vga_timing_decoder;

  logic clk = 1'b0;
  logic rst;
  logic locked, line_start, frame_start, pix_valid;
  logic [9:0] posx, posy;
  logic [11:0] h_period;
  logic [10:0] v_lines;
  logic err, err_sticky;
  logic [7:0] err_count;

  vga_timing_decoder_if vif();

  vga_timing_decoder #(
    .CW(12),
    .LINE_TOL(0),
    .MIN_LINES(4),
    .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vin(vif.slave),
    .locked(locked),
    .line_start(line_start),
    .frame_start(frame_start),
    .pix_valid(pix_valid),
    .posx(posx),
    .posy(posy),
    .h_period(h_period),
    .v_lines(v_lines),
    .err(err),
    .err_sticky(err_sticky),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

`ifdef VGA_DEC_ERRCNT_EN
  localparam int EC3   = 3;
  localparam int EC300 = 255;
`else
  localparam int EC3   = 0;
  localparam int EC300 = 0;
`endif

  int total = 0;
  int bad = 0;
  int tick = 0;
  int lst[0:15];

  int n_err = 0, n_fs = 0, n_ls = 0, n_pix = 0;
  int err_tick = 0, lock_tick = 0;
  int fx = 0, fy = 0, lx = 0, ly = 0;
  int pix_base = 0;
  logic lock_prev = 1'b0;

  always @(negedge clk) begin
    if (err) begin
      n_err++;
      err_tick = tick;
    end
    if (frame_start) n_fs++;
    if (line_start) n_ls++;
    if (pix_valid) begin
      if (n_pix == pix_base) begin
        fx = int'(posx);
        fy = int'(posy);
      end
      lx = int'(posx);
      ly = int'(posy);
      n_pix++;
    end
    if (locked && !lock_prev) lock_tick = tick;
    lock_prev = locked;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs, input logic bl);
    vif.h_sync  = hs;
    vif.v_sync  = vs;
    vif.blank_n = bl;
    @(posedge clk);
    tick++;
    #1;
  endtask

  task automatic line(input int l, input int len, input int nl);
    lst[l] = tick + 1;
    for (int c = 0; c < len; c++)
      step(!(c < 4), !(l < 2),
           (l >= 3 && l < nl - 2 && c >= 10 && c < 30));
  endtask

  task automatic frame(input int len, input int nl, input int sl);
    for (int l = 0; l < nl; l++)
      line(l, (l == sl) ? len + 1 : len, nl);
  endtask

  int e0, fs0, ls0;

  initial begin
    rst = 1'b1;
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("reset_outs",
        {locked, line_start, frame_start, pix_valid, posx, posy,
         h_period, v_lines, err, err_sticky, err_count}, 64'd0);
    rst = 1'b0;
    step(1, 1, 0);
    step(1, 1, 0);

    frame(40, 12, -1);
    chk("measure_unlocked", locked, 0);
    frame(40, 12, -1);
    chk("lock_tick", lock_tick, lst[0] + 1);
    chk("locked", locked, 1);
    chk("h_period", h_period, 40);
    chk("v_lines", v_lines, 12);

    e0 = n_err; fs0 = n_fs; ls0 = n_ls; pix_base = n_pix;
    frame(40, 12, -1);
    frame(40, 12, -1);
    chk("no_err_clean", n_err - e0, 0);
    chk("frame_start_cnt", n_fs - fs0, 2);
    chk("line_start_cnt", n_ls - ls0, 24);
    chk("pix_cnt", n_pix - pix_base, 280);
    chk("first_x", fx, 0);
    chk("first_y", fy, 0);
    chk("last_x", lx, 19);
    chk("last_y", ly, 6);

    e0 = n_err;
    frame(40, 12, 5);
    chk("stretch_err_cnt", n_err - e0, 1);
    chk("stretch_err_tick", err_tick, lst[6] + 1);
    chk("stretch_unlock", locked, 0);
    chk("stretch_sticky", err_sticky, 1);
    chk("stretch_hper_hold", h_period, 40);
    frame(40, 12, -1);
    chk("remeasure_unlocked", locked, 0);
    frame(40, 12, -1);
    chk("relock", locked, 1);

    e0 = n_err;
    for (int i = 0; i < 4200; i++) step(1, 1, 0);
    chk("tmo_err_cnt", n_err - e0, 1);
    chk("tmo_err_tick", err_tick, lst[11] + 4097);
    chk("tmo_unlock", locked, 0);
    frame(40, 12, -1);
    chk("tmo_search_measure", locked, 0);
    frame(40, 12, -1);
    chk("tmo_relock", locked, 1);

    for (int l = 0; l < 6; l++) line(l, 40, 12);
    rst = 1'b1;
    step(1, 1, 0);
    chk("midrst_outs",
        {locked, line_start, frame_start, pix_valid, posx, posy,
         h_period, v_lines, err, err_sticky, err_count}, 64'd0);
    rst = 1'b0;
    step(1, 1, 0);
    step(1, 1, 0);
    frame(40, 12, -1);
    chk("midrst_measure", locked, 0);
    frame(40, 12, -1);
    chk("midrst_relock", locked, 1);
    chk("midrst_sticky", err_sticky, 0);

    rst = 1'b1;
    step(1, 1, 0);
    rst = 1'b0;
    step(1, 1, 0);
    step(1, 1, 0);
    frame(8, 3, -1);
    frame(8, 4, -1);
    chk("short_frame_nolock", locked, 0);
    frame(8, 4, -1);
    frame(8, 4, -1);
    chk("min_lines_lock", locked, 1);
    chk("min_v_lines", v_lines, 4);
    chk("min_h_period", h_period, 8);

    e0 = n_err;
    for (int i = 0; i < 3; i++) begin
      frame(8, 4, 1);
      frame(8, 4, -1);
    end
    chk("errs_3", n_err - e0, 3);
    chk("err_count_3", err_count, EC3);
    for (int i = 0; i < 297; i++) begin
      frame(8, 4, 1);
      frame(8, 4, -1);
    end
    chk("errs_300", n_err - e0, 300);
    chk("err_count_sat", err_count, EC300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Receiving end of the VGA timing interface: consumes h_sync / v_sync / blank_n as driven by the display sync generator and recovers pixel coordinates, line period and frame height.
- Checks the timing for consistency frame by frame and reports lock and errors.
- Used as an on-chip monitor and as a video-input front end for downstream pixel consumers; runs in the pixel clock domain.

Parameters:
- CW, 12, width of the clock-per-line counter and of h_period.
- LINE_TOL, 0, allowed deviation (clocks) of a line period from the measured period.
- MIN_LINES, 100, minimum lines per frame accepted for lock.
- SYNC_ACTIVE_LOW, 1, 1: sync pulses are low; 0: sync pulses are high.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- h_sync  in  1  horizontal sync, same clock domain
- v_sync  in  1  vertical sync, same clock domain
- blank_n  in  1  high during active video
- locked  out  1  timing stable and being tracked
- line_start  out  1  one-cycle pulse on each sync leading edge while locked
- frame_start  out  1  one-cycle pulse on each vsync leading edge while locked
- pix_valid  out  1  active pixel this cycle (locked only)
- posx  out  10  active-pixel column
- posy  out  10  active-pixel row
- h_period  out  CW  measured clocks per line
- v_lines  out  11  measured lines per frame
- err  out  1  one-cycle pulse on a timing violation
- err_sticky  out  1  set by err, cleared only by rst
- err_count  out  8  violation count (see Optional Feature)

Behaviour:
- Reset values:
  - Every output is 0.
  - The FSM is in SEARCH.
  - All counters are 0.
- Input handling:
  - Inputs are registered once.
  - A leading edge is the transition into the active sync level. With SYNC_ACTIVE_LOW=1 this is a falling edge.
  - Edges are detected from the registered value versus its previous value, so all responses lag the pins by 1 clk.
- hcnt:
  - Counts clocks since the last hsync edge.
  - On an hsync edge: line length = hcnt+1; hcnt restarts at 0.
- lcnt:
  - Counts hsync edges since the last vsync edge.
- SEARCH:
  - Wait for a vsync edge, then clear hcnt and lcnt and go to MEASURE.
- MEASURE:
  - The first complete line length is stored into h_period.
  - Each subsequent line must match it within ±LINE_TOL. A mismatch returns to SEARCH with no err.
  - On the next vsync edge:
    - lcnt ≥ MIN_LINES: store lcnt into v_lines, set locked, go to LOCKED.
    - Otherwise: go to SEARCH.
- LOCKED:
  - Each line length is checked against h_period ±LINE_TOL.
  - Each frame's lcnt is checked against v_lines exactly.
  - On a violation: err pulse, err_sticky=1, locked=0, go to SEARCH.
  - h_period and v_lines hold their last values.
- Timeout: hcnt reaching 2^CW−1 in any state other than SEARCH goes to SEARCH. It also raises err if the FSM was in LOCKED.
- Simultaneous hsync and vsync edge in the same cycle:
  - The line check is evaluated first, then the frame check.
  - The frame's lcnt includes that line.
  - A single violation cycle produces a single err pulse.
- Position tracking:
  - pix_valid = registered blank_n AND locked.
  - posx = count of pix_valid cycles earlier in the current line; it is cleared at the hsync edge.
  - posy = count of earlier lines in the frame that contained ≥1 active pixel; it is cleared at the vsync edge.
  - posx and posy are only meaningful when pix_valid=1.
- Width rules: posx and posy saturate at 1023; lcnt saturates at 2047.
- Reset mid-frame: all outputs are 0 on the next cycle; lock is reacquired from SEARCH.

Optional Feature:
- Macro: VGA_DEC_ERRCNT_EN.
- Defined: err_count increments on each err pulse, saturates at 255, and is cleared by rst.
- Undefined: err_count is tied to 0 and the counter logic is absent.

Test Plan:
- Common stimulus: 800 clk/line, hsync low 96 clk, active h=144..783, 525 lines, vsync low lines 0..1, active v=35..514.
- Ideal frames after reset -> locked=1 from 1 clk after the second vsync edge; h_period=800, v_lines=525, err never asserts.
- Locked frame, first blank_n high -> pix_valid=1, posx=0, posy=0 one cycle later; final active pixel gives posx=639, posy=479; frame_start pulses once per 420000 clk.
- One line stretched to 801 clk while locked -> err pulse 1 clk after that line's hsync edge; locked=0, err_sticky=1; locked=1 again after one clean measurement frame.
- h_sync held inactive for 4095 clk while locked -> err pulse, locked=0, FSM in SEARCH.
- rst asserted mid-frame while locked -> all outputs 0 next cycle, including err_sticky; relock after two vsync edges.
- VGA_DEC_ERRCNT_EN defined, 3 injected violations -> err_count=3; 300 injected violations -> err_count=255. Macro undefined -> err_count stays 0.
